gps_acq_correlator: RTL and testbench



---
 rtl/gps_acq_correlator_pkg.sv | 47 ++++
 rtl/gps_ca_replica.sv | 52 +++++
 rtl/gps_acq_correlator.sv | 151 +++++++++++++++
 tb/tb_gps_acq_correlator.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/gps_acq_correlator_pkg.sv
// Shared constants, FSM encoding and the C/A G2 phase-select tap table.
// n_sat selects PRN n_sat+1; taps are returned as zero-based G2 stage indices.
package gps_acq_correlator_pkg;

  localparam int SPC_DEFAULT      = 16;
  localparam int CHIPS_DEFAULT    = 1023;
  localparam int SLIP_DEFAULT     = 8;
  localparam int NCO_DEFAULT      = 8000;
  localparam int PHASE_W          = 14;
  localparam int ACC_W            = 15;
  localparam int MAG_W            = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_INTEGRATE, S_DUMP, S_SLIP, S_DONE
  } state_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
  } g2_taps_t;

  function automatic g2_taps_t g2_taps(input logic [4:0] n_sat);
    g2_taps_t t;
    case (n_sat)
      5'd0:  t = '{4'd2, 4'd6};   5'd1:  t = '{4'd3, 4'd7};
      5'd2:  t = '{4'd4, 4'd8};   5'd3:  t = '{4'd5, 4'd9};
      5'd4:  t = '{4'd1, 4'd9};   5'd5:  t = '{4'd2, 4'd10};
      5'd6:  t = '{4'd1, 4'd8};   5'd7:  t = '{4'd2, 4'd9};
      5'd8:  t = '{4'd3, 4'd10};  5'd9:  t = '{4'd2, 4'd3};
      5'd10: t = '{4'd3, 4'd4};   5'd11: t = '{4'd5, 4'd6};
      5'd12: t = '{4'd6, 4'd7};   5'd13: t = '{4'd7, 4'd8};
      5'd14: t = '{4'd8, 4'd9};   5'd15: t = '{4'd9, 4'd10};
      5'd16: t = '{4'd1, 4'd4};   5'd17: t = '{4'd2, 4'd5};
      5'd18: t = '{4'd3, 4'd6};   5'd19: t = '{4'd4, 4'd7};
      5'd20: t = '{4'd5, 4'd8};   5'd21: t = '{4'd6, 4'd9};
      5'd22: t = '{4'd1, 4'd3};   5'd23: t = '{4'd4, 4'd6};
      5'd24: t = '{4'd5, 4'd7};   5'd25: t = '{4'd6, 4'd8};
      5'd26: t = '{4'd7, 4'd9};   5'd27: t = '{4'd8, 4'd10};
      5'd28: t = '{4'd1, 4'd6};   5'd29: t = '{4'd2, 4'd7};
      5'd30: t = '{4'd3, 4'd8};   default: t = '{4'd4, 4'd9};
    endcase
    t.a = t.a - 4'd1;
    t.b = t.b - 4'd1;
    return t;
  endfunction

endpackage

// File: rtl/gps_ca_replica.sv
// Local C/A replica: G1/G2 LFSRs, PRN tap mux and chip prescaler.
// The epoch restarts from all-ones after CODE_CHIPS chips.
module gps_ca_replica
  import gps_acq_correlator_pkg::*;
#(
  parameter int SAMPLES_PER_CHIP = SPC_DEFAULT,
  parameter int CODE_CHIPS       = CHIPS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       advance,
  input  logic [4:0] n_sat,
  output logic       rep
);

  localparam int PW = $clog2(SAMPLES_PER_CHIP + 1);
  localparam int KW = $clog2(CODE_CHIPS + 1);

  logic [PW-1:0] presc;
  logic [KW-1:0] chip_left;
  logic [9:0]    g1, g2;
  g2_taps_t      taps;

  assign taps = g2_taps(n_sat);
  assign rep  = g1[9] ^ g2[taps.a] ^ g2[taps.b];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      presc     <= PW'(SAMPLES_PER_CHIP - 1);
      chip_left <= KW'(CODE_CHIPS - 1);
      g1        <= '1;
      g2        <= '1;
    end else if (advance) begin
      if (presc == '0) begin
        presc <= PW'(SAMPLES_PER_CHIP - 1);
        if (chip_left == '0) begin
          chip_left <= KW'(CODE_CHIPS - 1);
          g1        <= '1;
          g2        <= '1;
        end else begin
          chip_left <= chip_left - 1'b1;
          g1        <= {g1[8:0], g1[2] ^ g1[9]};
          g2        <= {g2[8:0], g2[1] ^ g2[2] ^ g2[5] ^ g2[7] ^ g2[8] ^ g2[9]};
        end
      end else begin
        presc <= presc - 1'b1;
      end
    end
  end

endmodule

// File: rtl/gps_acq_correlator.sv
// Serial code-phase search on the 1-bit IF stream with I/Q carrier wipe-off.
//   IDLE      | waiting for start_in
//   CLEAR     | zero accumulators, replica, carrier and results
//   INTEGRATE | accumulate one code period of enabled samples
//   DUMP      | update peak tracker, decide next slip or finish
//   SLIP      | hold replica for SLIP_STEP enabled samples
//   DONE      | one-cycle done_out, results already latched
module gps_acq_correlator
  import gps_acq_correlator_pkg::*;
#(
  parameter int SAMPLES_PER_CHIP = SPC_DEFAULT,
  parameter int CODE_CHIPS       = CHIPS_DEFAULT,
  parameter int SLIP_STEP        = SLIP_DEFAULT,
  parameter int NCO_BASE         = NCO_DEFAULT
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 ena_in,
  input  logic                 start_in,
  input  logic                 sin_in,
  input  logic [4:0]           n_sat_in,
  input  logic [7:0]           doppler_in,
  input  logic [MAG_W-1:0]     threshold_in,
  output logic                 busy_out,
  output logic                 done_out,
  output logic                 found_out,
  output logic [PHASE_W-1:0]   code_phase_out,
  output logic [MAG_W-1:0]     peak_out
);

  localparam int CODE_SAMPLES = SAMPLES_PER_CHIP * CODE_CHIPS;
  localparam int SW           = PHASE_W + 1;

  state_t                    state, state_n;
  logic [ACC_W-1:0]          carrier, delta_phi, abs_i, abs_q;
  logic signed [ACC_W-1:0]   acc_i, acc_q;
  logic [PHASE_W-1:0]        samp_left, slip_left, slip, best_phase, phase_n;
  logic [MAG_W-1:0]          mag, best, best_n;
  logic                      rep, lo_sin, lo_cos, p_i, p_q, last_dwell, better;

  gps_ca_replica #(
    .SAMPLES_PER_CHIP(SAMPLES_PER_CHIP),
    .CODE_CHIPS      (CODE_CHIPS)
  ) u_replica (
    .clk    (clk_in),
    .rst    (rst_in),
    .clear  (state == S_CLEAR),
    .advance(ena_in && state == S_INTEGRATE),
    .n_sat  (n_sat_in),
    .rep    (rep)
  );

  assign delta_phi  = ACC_W'(NCO_BASE) + ACC_W'(doppler_in);
  assign lo_sin     = carrier[14];
  assign lo_cos     = carrier[14] ^ carrier[13];
  assign p_i        = sin_in ^ rep ^ lo_sin;
  assign p_q        = sin_in ^ rep ^ lo_cos;
  assign abs_i      = acc_i[ACC_W-1] ? -acc_i : acc_i;
  assign abs_q      = acc_q[ACC_W-1] ? -acc_q : acc_q;
  assign mag        = MAG_W'(abs_i) + MAG_W'(abs_q);
  // strict compare keeps the earliest dwell on ties
  assign better     = mag > best;
  assign best_n     = better ? mag : best;
  assign phase_n    = better ? slip : best_phase;
  assign last_dwell = (SW'(slip) + SW'(SLIP_STEP)) >= SW'(CODE_SAMPLES);

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    busy_out = 1'b1;
    done_out = 1'b0;
    case (state)
      S_IDLE: begin
        busy_out = 1'b0;
        if (start_in) state_n = S_CLEAR;
      end
      S_CLEAR:     state_n = S_INTEGRATE;
      S_INTEGRATE: if (ena_in && samp_left == '0) state_n = S_DUMP;
      S_DUMP:      state_n = last_dwell ? S_DONE : S_SLIP;
      S_SLIP:      if (ena_in && slip_left == '0) state_n = S_INTEGRATE;
      S_DONE: begin
        busy_out = 1'b0;
        done_out = 1'b1;
        state_n  = S_IDLE;
      end
      default: begin
        busy_out = 1'b0;
        state_n  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      carrier        <= '0;
      acc_i          <= '0;
      acc_q          <= '0;
      samp_left      <= '0;
      slip_left      <= '0;
      slip           <= '0;
      best           <= '0;
      best_phase     <= '0;
      found_out      <= 1'b0;
      code_phase_out <= '0;
      peak_out       <= '0;
    end else begin
      if (state == S_CLEAR) carrier <= '0;
      else if (ena_in)      carrier <= carrier + delta_phi;
      case (state)
        S_CLEAR: begin
          acc_i          <= '0;
          acc_q          <= '0;
          samp_left      <= PHASE_W'(CODE_SAMPLES - 1);
          slip           <= '0;
          best           <= '0;
          best_phase     <= '0;
          found_out      <= 1'b0;
          code_phase_out <= '0;
          peak_out       <= '0;
        end
        S_INTEGRATE: if (ena_in) begin
          acc_i     <= p_i ? acc_i - 1'b1 : acc_i + 1'b1;
          acc_q     <= p_q ? acc_q - 1'b1 : acc_q + 1'b1;
          samp_left <= samp_left - 1'b1;
        end
        S_DUMP: begin
          best       <= best_n;
          best_phase <= phase_n;
          acc_i      <= '0;
          acc_q      <= '0;
          samp_left  <= PHASE_W'(CODE_SAMPLES - 1);
          slip_left  <= PHASE_W'(SLIP_STEP - 1);
          if (last_dwell) begin
            found_out      <= best_n >= threshold_in;
            code_phase_out <= phase_n;
            peak_out       <= best_n;
          end else begin
            slip <= slip + PHASE_W'(SLIP_STEP);
          end
        end
        S_SLIP: if (ena_in) slip_left <= slip_left - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gps_acq_correlator.sv
// Self-checking bench for gps_acq_correlator with a shortened code so full searches fit.
// Expected results come from a correlation model evaluated over the generated IF stream.
module tb_gps_acq_correlator;

  localparam int SPC    = 4;
  localparam int CHIPS  = 15;
  localparam int STEP   = 2;
  localparam int NBASE  = 8000;
  localparam int N      = SPC * CHIPS;
  localparam int NDWELL = (N + STEP - 1) / STEP;
  localparam int SLEN   = NDWELL * (N + STEP);

  logic        clk = 1'b0;
  logic        rst = 1'b0, ena = 1'b0, start = 1'b0, sin = 1'b0;
  logic [4:0]  n_sat = '0;
  logic [7:0]  doppler = '0;
  logic [15:0] threshold = '0;
  logic        busy, done, found;
  logic [13:0] code_phase;
  logic [15:0] peak;

  int vectors = 0, miscompares = 0;
  int tap_a [32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
  int tap_b [32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};
  bit code_tab [32][CHIPS];
  bit stream [SLEN];
  int e_peak, e_phase, ideal_dly;
  bit e_found;

  gps_acq_correlator #(
    .SAMPLES_PER_CHIP(SPC), .CODE_CHIPS(CHIPS), .SLIP_STEP(STEP), .NCO_BASE(NBASE)
  ) dut (
    .clk_in(clk), .rst_in(rst), .ena_in(ena), .start_in(start), .sin_in(sin),
    .n_sat_in(n_sat), .doppler_in(doppler), .threshold_in(threshold),
    .busy_out(busy), .done_out(done), .found_out(found),
    .code_phase_out(code_phase), .peak_out(peak)
  );

  always #5 clk = ~clk;

  task automatic build_codes();
    bit g1 [1:10];
    bit g2 [1:10];
    bit f1, f2;
    for (int p = 0; p < 32; p++) begin
      for (int i = 1; i <= 10; i++) begin g1[i] = 1'b1; g2[i] = 1'b1; end
      for (int c = 0; c < CHIPS; c++) begin
        code_tab[p][c] = g1[10] ^ g2[tap_a[p]] ^ g2[tap_b[p]];
        f1 = g1[3] ^ g1[10];
        f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
        for (int i = 10; i > 1; i--) begin g1[i] = g1[i-1]; g2[i] = g2[i-1]; end
        g1[1] = f1;
        g2[1] = f2;
      end
    end
  endtask

  function automatic int car_bit(input int g, input int delta, input int b);
    longint ph;
    ph = (longint'(g) * longint'(delta)) % 64'sd32768;
    return int'((ph >> b) & 64'sd1);
  endfunction

  // input stream index g counts enabled samples after CLEAR; code delayed by dly samples
  task automatic make_stream(input int prn, input int dop, input int dly, input int noise_pct);
    int idx, nz;
    for (int g = 0; g < SLEN; g++) begin
      idx = ((g - dly) % N + N) % N;
      nz  = ($urandom_range(0, 99) < noise_pct) ? 1 : 0;
      stream[g] = bit'(int'(code_tab[prn][idx / SPC]) ^ car_bit(g, NBASE + dop, 14) ^ nz);
    end
  endtask

  // dwell d covers stream samples d*(N+STEP) .. +N-1 against replica samples 0..N-1
  task automatic model(input int nsat, input int dop);
    int g, ia, qa, mag, rep, ls, lc, s;
    e_peak = 0;
    e_phase = 0;
    for (int d = 0; d < NDWELL; d++) begin
      ia = 0; qa = 0;
      for (int j = 0; j < N; j++) begin
        g   = d * (N + STEP) + j;
        rep = int'(code_tab[nsat][j / SPC]);
        ls  = car_bit(g, NBASE + dop, 14);
        lc  = ls ^ car_bit(g, NBASE + dop, 13);
        s   = int'(stream[g]);
        ia += ((s ^ rep ^ ls) != 0) ? -1 : 1;
        qa += ((s ^ rep ^ lc) != 0) ? -1 : 1;
      end
      mag = (ia < 0 ? -ia : ia) + (qa < 0 ? -qa : qa);
      if (mag > e_peak) begin e_peak = mag; e_phase = d * STEP; end
    end
  endtask

  task automatic feed(input int count, input int ena_pct, input bit repulse, inout int g);
    int k = 0;
    while (k < count) begin
      @(negedge clk);
      start = repulse && ($urandom_range(0, 99) < 5);
      if ($urandom_range(1, 100) <= ena_pct) begin
        ena = 1'b1; sin = stream[g]; g++; k++;
      end else begin
        ena = 1'b0; sin = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic do_search(input int nsat, input int dop, input int thr, input int ena_pct,
                           input bit repulse, input string name);
    int g = 0;
    n_sat = 5'(nsat); doppler = 8'(dop); threshold = 16'(thr);
    e_found = (e_peak >= thr);
    @(negedge clk); start = 1'b1; ena = 1'b0;
    @(negedge clk); start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL %s busy_in_clear: got %b want 1", name, busy); end
    for (int d = 0; d < NDWELL; d++) begin
      feed(N, ena_pct, repulse, g);
      @(negedge clk); start = 1'b0; ena = 1'b0; sin = 1'($urandom_range(0, 1));
      if (d == 0) begin
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0 || peak !== 16'd0 || code_phase !== 14'd0) begin
          miscompares++;
          $display("FAIL %s mid_search: got busy=%b done=%b peak=%0d phase=%0d want 1 0 0 0",
                   name, busy, done, peak, code_phase);
        end
      end
      if (d != NDWELL - 1) feed(STEP, ena_pct, repulse, g);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL %s done_pulse: got done=%b busy=%b want 1 0", name, done, busy);
    end
    vectors++;
    if (peak !== 16'(e_peak)) begin miscompares++; $display("FAIL %s peak: got %0d want %0d", name, peak, e_peak); end
    vectors++;
    if (code_phase !== 14'(e_phase)) begin
      miscompares++; $display("FAIL %s code_phase: got %0d want %0d", name, code_phase, e_phase);
    end
    vectors++;
    if (found !== e_found) begin miscompares++; $display("FAIL %s found: got %b want %b", name, found, e_found); end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || peak !== 16'(e_peak) || code_phase !== 14'(e_phase)) begin
      miscompares++;
      $display("FAIL %s hold_after_done: got done=%b busy=%b peak=%0d phase=%0d want 0 0 %0d %0d",
               name, done, busy, peak, code_phase, e_peak, e_phase);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (found !== 1'b0) begin miscompares++; $display("FAIL reset_found: got %b want 0", found); end
    vectors++; if (code_phase !== 14'd0) begin miscompares++; $display("FAIL reset_phase: got %0d want 0", code_phase); end
    vectors++; if (peak !== 16'd0) begin miscompares++; $display("FAIL reset_peak: got %0d want 0", peak); end
    rst = 1'b0;
  endtask

  task automatic test_ideal();
    ideal_dly = STEP * int'($urandom_range(0, NDWELL - 1));
    make_stream(0, 0, ideal_dly, 0);
    model(0, 0);
    do_search(0, 0, e_peak, 100, 1'b0, "ideal");
    vectors++;
    if (int'(peak) < N) begin miscompares++; $display("FAIL ideal_peak_floor: got %0d want >= %0d", peak, N); end
  endtask

  task automatic test_off_grid();
    int dop = int'($urandom_range(0, 255));
    make_stream(0, dop, 2 * int'($urandom_range(0, N / 2 - 1)) + 1, 0);
    model(0, dop);
    do_search(0, dop, int'($urandom_range(0, 2 * N)), 100, 1'b0, "off_grid");
  endtask

  task automatic test_wrong_prn();
    make_stream(1, 0, STEP * int'($urandom_range(0, NDWELL - 1)), 0);
    model(0, 0);
    do_search(0, 0, e_peak + 1, 100, 1'b0, "wrong_prn");
  endtask

  task automatic test_ena_toggle();
    make_stream(0, 0, ideal_dly, 0);
    model(0, 0);
    do_search(0, 0, N / 2, 50, 1'b0, "ena_toggle");
  endtask

  task automatic test_busy_controls();
    int g = 0;
    make_stream(2, 17, int'($urandom_range(0, N - 1)), 5);
    model(2, 17);
    do_search(2, 17, N / 2, 90, 1'b1, "start_repulse");
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    feed(N / 2, 100, 1'b0, g);
    @(negedge clk); rst = 1'b1; ena = 1'b0;
    @(negedge clk); rst = 1'b0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || found !== 1'b0 || peak !== 16'd0 || code_phase !== 14'd0) begin
      miscompares++;
      $display("FAIL abort: got busy=%b done=%b found=%b peak=%0d phase=%0d want all 0",
               busy, done, found, peak, code_phase);
    end
    do_search(2, 17, N / 2, 90, 1'b0, "after_abort");
  endtask

  task automatic test_random();
    int prn, dop, noise;
    for (int it = 0; it < 2; it++) begin
      prn   = int'($urandom_range(0, 31));
      dop   = int'($urandom_range(0, 255));
      noise = int'($urandom_range(0, 20));
      make_stream(prn, dop, int'($urandom_range(0, N - 1)), noise);
      model(prn, dop);
      do_search(prn, dop, int'($urandom_range(N / 4, N)), int'($urandom_range(60, 100)), 1'b0, "random");
    end
  endtask

  initial begin
    build_codes();
    test_reset();
    test_ideal();
    test_off_grid();
    test_wrong_prn();
    test_ena_toggle();
    test_busy_controls();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
